// File: rtl/lsu_icb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_icb_ctrl_pkg
// Purpose  : Shared state encoding and access-size codes for the LSU ICB
//            controller and its load-extract helper.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_icb_ctrl_pkg;

  localparam int LSU_STATE_WIDTH = 2;

  // Controller sequencing states: accept, issue, await response, commit
  typedef enum logic [LSU_STATE_WIDTH-1:0] {
    LSU_STATE_IDLE = 2'd0,
    LSU_STATE_CMD  = 2'd1,
    LSU_STATE_RSP  = 2'd2,
    LSU_STATE_WBCK = 2'd3
  } lsu_state_e;

  // Access size codes; 2'b11 is handled as a word access
  localparam logic [1:0] LSU_SIZE_B  = 2'b00;
  localparam logic [1:0] LSU_SIZE_HW = 2'b01;
  localparam logic [1:0] LSU_SIZE_W  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/lsu_ld_extract.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ld_extract
// Purpose  : Combinational load alignment: shifts the raw bus word down by
//            the byte offset and sign/zero-extends byte and half loads.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ld_extract
  import lsu_icb_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_addr_lo,
  input  logic [1:0]      i_size,
  input  logic            i_usign,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_word;

  // Align the addressed lane to bit 0, then extend by access size
  always_comb begin
    w_word = i_rdata >> {i_addr_lo, 3'b000};
    o_data = i_rdata;
    case (i_size)
      LSU_SIZE_B:  o_data = {{(XLEN-8){~i_usign & w_word[7]}}, w_word[7:0]};
      LSU_SIZE_HW: o_data = {{(XLEN-16){~i_usign & w_word[15]}}, w_word[15:0]};
      LSU_SIZE_W,
      2'b11:       o_data = i_rdata;
      default:     o_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_icb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_icb_ctrl
// Purpose  : Single-outstanding LSU sequencer: takes one AGU command, issues
//            it on the data-memory ICB, waits for the response, extends load
//            data and commits it on the write-back interface.
// Config   : LSU_MISALIGN_CHK_EN - when defined, misaligned half/word
//            accesses bypass the bus and commit with a misalign flag.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_icb_ctrl
  import lsu_icb_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_i_valid,
  output logic                 lsu_i_ready,
  input  logic [ADDR_SIZE-1:0] lsu_i_addr,
  input  logic                 lsu_i_read,
  input  logic [XLEN-1:0]      lsu_i_wdata,
  input  logic [XLEN/8-1:0]    lsu_i_wmask,
  input  logic [1:0]           lsu_i_size,
  input  logic                 lsu_i_usign,
  input  logic [4:0]           lsu_i_rdidx,
  output logic                 mem_cmd_valid,
  input  logic                 mem_cmd_ready,
  output logic [ADDR_SIZE-1:0] mem_cmd_addr,
  output logic                 mem_cmd_read,
  output logic [XLEN-1:0]      mem_cmd_wdata,
  output logic [XLEN/8-1:0]    mem_cmd_wmask,
  input  logic                 mem_rsp_valid,
  output logic                 mem_rsp_ready,
  input  logic [XLEN-1:0]      mem_rsp_rdata,
  input  logic                 mem_rsp_err,
  output logic                 lsu_o_valid,
  input  logic                 lsu_o_ready,
  output logic [XLEN-1:0]      lsu_o_wbck_wdat,
  output logic                 lsu_o_wbck_err,
  output logic                 lsu_o_misalgn,
  output logic                 lsu_o_ld,
  output logic [4:0]           lsu_o_rdidx,
  output logic                 lsu_busy
);

  lsu_state_e             state_q, state_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic                   read_q, read_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;
  logic [XLEN/8-1:0]      wmask_q, wmask_d;
  logic [1:0]             size_q, size_d;
  logic                   usign_q, usign_d;
  logic [4:0]             rdidx_q, rdidx_d;
  logic [XLEN-1:0]        wdat_q, wdat_d;
  logic                   err_q, err_d;
  logic [XLEN-1:0]        w_ld_data;
`ifdef LSU_MISALIGN_CHK_EN
  logic                   misalgn_q, misalgn_d;
  logic                   w_misalgn;
`endif

  lsu_ld_extract #(.XLEN(XLEN)) u_ld_extract (
    .i_rdata   (mem_rsp_rdata),
    .i_addr_lo (addr_q[1:0]),
    .i_size    (size_q),
    .i_usign   (usign_q),
    .o_data    (w_ld_data)
  );

`ifdef LSU_MISALIGN_CHK_EN
  // Half needs 2-byte alignment; word (and size 11) needs 4-byte alignment
  always_comb begin
    w_misalgn = ((lsu_i_size == LSU_SIZE_HW) && lsu_i_addr[0]) ||
                (lsu_i_size[1] && (lsu_i_addr[1:0] != 2'b00));
  end
`endif

  // Next-state and capture logic for the four-phase transaction sequence
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    read_d  = read_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    size_d  = size_q;
    usign_d = usign_q;
    rdidx_d = rdidx_q;
    wdat_d  = wdat_q;
    err_d   = err_q;
`ifdef LSU_MISALIGN_CHK_EN
    misalgn_d = misalgn_q;
`endif
    case (state_q)
      LSU_STATE_IDLE: begin
        if (lsu_i_valid) begin
          addr_d  = lsu_i_addr;
          read_d  = lsu_i_read;
          wdata_d = lsu_i_wdata;
          wmask_d = lsu_i_wmask;
          size_d  = lsu_i_size;
          usign_d = lsu_i_usign;
          rdidx_d = lsu_i_rdidx;
          wdat_d  = '0;
          err_d   = 1'b0;
          state_d = LSU_STATE_CMD;
`ifdef LSU_MISALIGN_CHK_EN
          misalgn_d = 1'b0;
          if (w_misalgn) begin
            // Faulting access never reaches the bus; report its address
            misalgn_d = 1'b1;
            wdat_d    = XLEN'(lsu_i_addr);
            state_d   = LSU_STATE_WBCK;
          end
`endif
        end
      end
      LSU_STATE_CMD: begin
        if (mem_cmd_ready) state_d = LSU_STATE_RSP;
      end
      LSU_STATE_RSP: begin
        if (mem_rsp_valid) begin
          err_d   = mem_rsp_err;
          wdat_d  = (mem_rsp_err || !read_q) ? '0 : w_ld_data;
          state_d = LSU_STATE_WBCK;
        end
      end
      LSU_STATE_WBCK: begin
        if (lsu_o_ready) state_d = LSU_STATE_IDLE;
      end
      default: state_d = LSU_STATE_IDLE;
    endcase
  end

  // State and captured-transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_STATE_IDLE;
      addr_q  <= '0;
      read_q  <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      size_q  <= '0;
      usign_q <= 1'b0;
      rdidx_q <= '0;
      wdat_q  <= '0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
      misalgn_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      size_q  <= size_d;
      usign_q <= usign_d;
      rdidx_q <= rdidx_d;
      wdat_q  <= wdat_d;
      err_q   <= err_d;
`ifdef LSU_MISALIGN_CHK_EN
      misalgn_q <= misalgn_d;
`endif
    end
  end

  // Handshakes decode directly from the state register; payloads from captures
  always_comb begin
    lsu_i_ready     = (state_q == LSU_STATE_IDLE);
    mem_cmd_valid   = (state_q == LSU_STATE_CMD);
    mem_rsp_ready   = (state_q == LSU_STATE_RSP);
    lsu_o_valid     = (state_q == LSU_STATE_WBCK);
    lsu_busy        = (state_q != LSU_STATE_IDLE);
    mem_cmd_addr    = addr_q;
    mem_cmd_read    = read_q;
    mem_cmd_wdata   = wdata_q;
    mem_cmd_wmask   = wmask_q;
    lsu_o_wbck_wdat = wdat_q;
    lsu_o_wbck_err  = err_q;
    lsu_o_ld        = read_q;
    lsu_o_rdidx     = rdidx_q;
`ifdef LSU_MISALIGN_CHK_EN
    lsu_o_misalgn   = misalgn_q;
`else
    lsu_o_misalgn   = 1'b0;
`endif
  end

endmodule
`default_nettype wire
